clk_div_gen: RTL and testbench

//  Programmable derived-clock generator driven from the primary clock pclock.

---
 rtl/clk_div_gen.sv | 182 ++++++++++++++++++
 tb/tb_clk_div_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Programmable derived-clock generator: registered gclock with configurable high, low and start-phase
// times counted in pclock cycles, reconfigurable on the fly at period boundaries.
module clk_div_gen #(
    parameter int CNT_W = 8
) (
    input  logic             pclock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             stop,
    output logic             gclock,
    output logic             gclock_rise,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic [CNT_W-1:0] pend_low_q, pend_low_d;
    logic [CNT_W-1:0] pend_phase_q, pend_phase_d;
    logic             pending_q, pending_d;
    logic             stop_req_q, stop_req_d;
    logic             gclock_q, gclock_d;
    logic             gclock_rise_q, gclock_rise_d;
    logic             busy_q, busy_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             running;
    logic             stop_now;
    logic             accept;
    logic [CNT_W-1:0] new_high;
    logic [CNT_W-1:0] new_low;
    logic [CNT_W-1:0] cnt_dec;

    assign cfg_ready   = cfg_ready_q;
    assign gclock      = gclock_q;
    assign gclock_rise = gclock_rise_q;
    assign busy        = busy_q;

    // A new configuration enters through PHASE with cnt=P, so the accept cycle itself counts as the
    // first low cycle and gclock (which tracks the HIGH state) rises P+1 edges after the accept.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_d        = high_q;
        low_d         = low_q;
        pend_high_d   = pend_high_q;
        pend_low_d    = pend_low_q;
        pend_phase_d  = pend_phase_q;
        pending_d     = pending_q;
        stop_req_d    = stop_req_q;

        running  = (state_q != IDLE);
        stop_now = running & (stop | stop_req_q);
        accept   = cfg_valid & cfg_ready_q & ~stop_now;
        new_high = (cfg_high == '0) ? CNT_ONE : cfg_high;
        new_low  = (cfg_low == '0) ? CNT_ONE : cfg_low;
        cnt_dec  = cnt_q - CNT_ONE;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    high_d  = new_high;
                    low_d   = new_low;
                    cnt_d   = cfg_phase;
                    state_d = PHASE;
                end
            end
            PHASE: begin
                if (stop_now) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = high_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = low_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            LOW: begin
                // End of a full period: the only place a stop or a pending config takes effect.
                if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else if (stop_now) begin
                    state_d = IDLE;
                end else if (pending_q) begin
                    high_d    = pend_high_q;
                    low_d     = pend_low_q;
                    pending_d = 1'b0;
                    if (pend_phase_q != '0) begin
                        state_d = PHASE;
                        cnt_d   = pend_phase_q - CNT_ONE;
                    end else begin
                        state_d = HIGH;
                        cnt_d   = pend_high_q - CNT_ONE;
                    end
                end else begin
                    state_d = HIGH;
                    cnt_d   = high_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (running && accept) begin
            pend_high_d  = new_high;
            pend_low_d   = new_low;
            pend_phase_d = cfg_phase;
            pending_d    = 1'b1;
        end
        if (stop_now) begin
            pending_d = 1'b0;
        end
        if (running && stop) begin
            stop_req_d = 1'b1;
        end
        if (state_d == IDLE) begin
            stop_req_d = 1'b0;
        end

        gclock_d      = (state_d == HIGH);
        gclock_rise_d = gclock_d & ~gclock_q;
        busy_d        = (state_d != IDLE);
        cfg_ready_d   = ~pending_d;
    end

    always_ff @(posedge pclock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            high_q        <= CNT_ONE;
            low_q         <= CNT_ONE;
            pend_high_q   <= CNT_ONE;
            pend_low_q    <= CNT_ONE;
            pend_phase_q  <= '0;
            pending_q     <= 1'b0;
            stop_req_q    <= 1'b0;
            gclock_q      <= 1'b0;
            gclock_rise_q <= 1'b0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_q        <= high_d;
            low_q         <= low_d;
            pend_high_q   <= pend_high_d;
            pend_low_q    <= pend_low_d;
            pend_phase_q  <= pend_phase_d;
            pending_q     <= pending_d;
            stop_req_q    <= stop_req_d;
            gclock_q      <= gclock_d;
            gclock_rise_q <= gclock_rise_d;
            busy_q        <= busy_d;
            cfg_ready_q   <= cfg_ready_d;
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios then random traffic, checked every cycle against a
// waveform-queue model of the expected gclock/busy/cfg_ready behaviour.
module tb_clk_div_gen;

    logic       pclock = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_high;
    logic [7:0] cfg_low;
    logic [7:0] cfg_phase;
    logic       stop;
    logic       gclock;
    logic       gclock_rise;
    logic       busy;

    clk_div_gen #(.CNT_W(8)) dut (
        .pclock      (pclock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .cfg_phase   (cfg_phase),
        .stop        (stop),
        .gclock      (gclock),
        .gclock_rise (gclock_rise),
        .busy        (busy)
    );

    always #5 pclock = ~pclock;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rise_times[$];

    // Model: queue of future gclock cycles (0 = phase low, 1 = high, 2 = low), refilled one period
    // at a time; an empty queue marks the end of a period.
    int m_q[$];
    bit m_run;
    int m_last;
    int m_h, m_l;
    bit m_pend;
    int m_ph, m_pl, m_pp;
    bit m_stopreq;
    bit exp_g, exp_rise, exp_busy, exp_ready;

    function automatic int clamp(input logic [7:0] v);
        return (v == 8'd0) ? 1 : int'(v);
    endfunction

    task automatic pushPeriod(input int h, input int l);
        for (int i = 0; i < h; i++) m_q.push_back(1);
        for (int i = 0; i < l; i++) m_q.push_back(2);
    endtask

    task automatic modelEdge();
        bit prev_g;
        bit stop_now;
        bit accept;
        int kind;
        prev_g = exp_g;
        if (reset) begin
            m_q.delete();
            m_run = 0; m_pend = 0; m_stopreq = 0; m_last = 2;
            exp_g = 0; exp_rise = 0; exp_busy = 0; exp_ready = 1;
            return;
        end
        if (!m_run) begin
            if (cfg_valid) begin
                m_h = clamp(cfg_high);
                m_l = clamp(cfg_low);
                m_run = 1;
                m_q.delete();
                m_q.push_back(0);
                for (int i = 0; i < int'(cfg_phase); i++) m_q.push_back(0);
                pushPeriod(m_h, m_l);
            end
        end else begin
            stop_now = stop || m_stopreq;
            accept   = cfg_valid && exp_ready && !stop_now;
            if (stop) m_stopreq = 1;
            if (stop_now) m_pend = 0;
            if (stop_now && m_last == 0) begin
                m_run = 0;
                m_q.delete();
            end else if (m_q.size() == 0) begin
                if (stop_now) begin
                    m_run = 0;
                end else begin
                    if (m_pend) begin
                        m_h = m_ph;
                        m_l = m_pl;
                        for (int i = 0; i < m_pp; i++) m_q.push_back(0);
                        m_pend = 0;
                    end
                    pushPeriod(m_h, m_l);
                end
            end
            if (accept) begin
                m_pend = 1;
                m_ph = clamp(cfg_high);
                m_pl = clamp(cfg_low);
                m_pp = int'(cfg_phase);
            end
        end
        if (m_run) begin
            kind = m_q.pop_front();
            m_last = kind;
        end else begin
            kind = 2;
            m_stopreq = 0;
            m_pend = 0;
        end
        exp_g     = m_run && (kind == 1);
        exp_rise  = exp_g && !prev_g;
        exp_busy  = m_run;
        exp_ready = !m_pend;
    endtask

    task automatic checkOutput(input string tag);
        compared++;
        assert (gclock === exp_g) else begin
            mismatched++;
            $error("[TB] FAIL %s gclock observed=%0b expected=%0b cycle=%0d", tag, gclock, exp_g, cyc);
        end
        compared++;
        assert (gclock_rise === exp_rise) else begin
            mismatched++;
            $error("[TB] FAIL %s gclock_rise observed=%0b expected=%0b cycle=%0d", tag, gclock_rise, exp_rise, cyc);
        end
        compared++;
        assert (busy === exp_busy) else begin
            mismatched++;
            $error("[TB] FAIL %s busy observed=%0b expected=%0b cycle=%0d", tag, busy, exp_busy, cyc);
        end
        compared++;
        assert (cfg_ready === exp_ready) else begin
            mismatched++;
            $error("[TB] FAIL %s cfg_ready observed=%0b expected=%0b cycle=%0d", tag, cfg_ready, exp_ready, cyc);
        end
        if (gclock_rise === 1'b1) rise_times.push_back(cyc);
    endtask

    task automatic expectInt(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge pclock);
        modelEdge();
        #1;
        cyc++;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input bit v, input int h, input int l, input int p, input bit s,
                                 input string tag);
        cfg_valid = v;
        cfg_high  = 8'(h);
        cfg_low   = 8'(l);
        cfg_phase = 8'(p);
        stop      = s;
        cycle(tag);
        cfg_valid = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0, tag);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        cycle(tag);
        reset = 1'b0;
    endtask

    function automatic int lastPeriod();
        if (rise_times.size() < 2) return -1;
        return rise_times[rise_times.size() - 1] - rise_times[rise_times.size() - 2];
    endfunction

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; stop = 1'b0;
        cfg_high = 8'd0; cfg_low = 8'd0; cfg_phase = 8'd0;
        m_run = 0; m_pend = 0; m_stopreq = 0; m_last = 2;
        exp_g = 0; exp_rise = 0; exp_busy = 0; exp_ready = 1;

        $display("[TB] reset and idle");
        doReset("reset");
        doReset("reset");
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 0, 0, 0, (i % 5) == 0, "idle");
        expectInt("idle_gclock", int'(gclock), 0);

        $display("[TB] H=2 L=3 P=0");
        rise_times.delete();
        applyStimulus(1'b1, 2, 3, 0, 1'b0, "cfg235_accept");
        expectInt("cfg235_first_rise", int'(gclock), 1'b0);
        cycle("cfg235_e1");
        expectInt("cfg235_rise_at_e1", int'(gclock), 1);
        idleCycles(15, "cfg235_run");
        expectInt("cfg235_period", lastPeriod(), 5);

        $display("[TB] H=0 L=0 P=4 clamped");
        doReset("reset");
        rise_times.delete();
        applyStimulus(1'b1, 0, 0, 4, 1'b0, "clamp_accept");
        idleCycles(12, "clamp_run");
        expectInt("clamp_first_rise_offset", (rise_times.size() > 0) ? rise_times[0] - (cyc - 12) : -1, 5);
        expectInt("clamp_period", lastPeriod(), 2);

        $display("[TB] reconfigure while running");
        doReset("reset");
        applyStimulus(1'b1, 2, 2, 0, 1'b0, "reconf_accept");
        idleCycles(5, "reconf_run");
        expectInt("reconf_in_high", int'(gclock), 1);
        applyStimulus(1'b1, 1, 3, 2, 1'b0, "reconf_pending");
        expectInt("reconf_ready_low", int'(cfg_ready), 0);
        rise_times.delete();
        idleCycles(20, "reconf_new");
        expectInt("reconf_period", lastPeriod(), 4);

        $display("[TB] stop in HIGH and in PHASE");
        doReset("reset");
        applyStimulus(1'b1, 3, 3, 0, 1'b0, "stop_accept");
        idleCycles(2, "stop_high");
        applyStimulus(1'b0, 0, 0, 0, 1'b1, "stop_req");
        applyStimulus(1'b1, 2, 2, 0, 1'b0, "stop_cfg_refused");
        idleCycles(8, "stop_drain");
        expectInt("stop_busy_idle", int'(busy), 0);
        expectInt("stop_gclock_idle", int'(gclock), 0);
        applyStimulus(1'b1, 1, 1, 5, 1'b0, "phase_accept");
        idleCycles(2, "phase_run");
        applyStimulus(1'b0, 0, 0, 0, 1'b1, "phase_stop");
        expectInt("phase_stop_busy", int'(busy), 0);
        idleCycles(3, "phase_idle");

        $display("[TB] reset while gclock high");
        applyStimulus(1'b1, 4, 1, 0, 1'b0, "rst_accept");
        cycle("rst_high");
        expectInt("rst_gclock_high", int'(gclock), 1);
        doReset("rst_mid");
        expectInt("rst_gclock_low", int'(gclock), 0);
        applyStimulus(1'b1, 1, 1, 0, 1'b0, "rst_restart");
        cycle("rst_restart_e1");
        expectInt("rst_restart_rise", int'(gclock), 1);
        idleCycles(4, "rst_restart_run");

        $display("[TB] random traffic");
        doReset("reset");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset("rand_reset");
            end else begin
                applyStimulus($urandom_range(0, 5) == 0,
                              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                              int'($urandom_range(0, 4)), $urandom_range(0, 39) == 0, "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
